// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional divider enabled with `define MULDIV_DIV_EN; without it, opcode 0111 is unsupported.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);
    localparam logic [3:0]         OP_MUL   = 4'b0100;
    localparam logic [3:0]         OP_UMULL = 4'b0110;
    localparam logic [3:0]         OP_SMULL = 4'b1000;
    localparam logic [3:0]         OP_DIV   = 4'b0111;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        mag = v[WIDTH-1] ? ((~v) + ONE_W) : v;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   p_hi_q, p_hi_d;
    logic [WIDTH-1:0]   p_lo_q, p_lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [1:0]         flags_q, flags_d;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] prod_s;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH:0]     trial_s;
`endif

    // Next-state, datapath step and result capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        b_d      = b_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
        sum_s    = {1'b0, p_hi_q} + {1'b0, b_q};
        // sign_q is only ever set for SMULL
        prod_s   = sign_q ? ((~{p_hi_q, p_lo_q}) + ONE_2W) : {p_hi_q, p_lo_q};
`ifdef MULDIV_DIV_EN
        rem_d    = rem_q;
        trial_s  = (rem_q << 1) | {ZERO_W, p_lo_q[WIDTH-1]};
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = ALUControl;
                    cnt_d  = {CNT_W{1'b0}};
                    sign_d = 1'b0;
                    p_hi_d = ZERO_W;
                    busy_d = 1'b1;
                    case (ALUControl)
                        OP_MUL, OP_UMULL: begin
                            b_d     = SrcA;
                            p_lo_d  = SrcB;
                            state_d = S_RUN;
                        end
                        OP_SMULL: begin
                            b_d     = mag(SrcA);
                            p_lo_d  = mag(SrcB);
                            sign_d  = SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
                            state_d = S_RUN;
                        end
`ifdef MULDIV_DIV_EN
                        OP_DIV: begin
                            b_d     = SrcB;
                            p_lo_d  = SrcA;
                            rem_d   = {(WIDTH+1){1'b0}};
                            state_d = (SrcB == ZERO_W) ? S_FIX : S_RUN;
                        end
`endif
                        default: begin
                            b_d     = ZERO_W;
                            p_lo_d  = ZERO_W;
                            state_d = S_FIX;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
`ifdef MULDIV_DIV_EN
                if (op_q == OP_DIV) begin
                    if (trial_s >= {1'b0, b_q}) begin
                        rem_d  = trial_s - {1'b0, b_q};
                        p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d  = trial_s;
                        p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else
`endif
                begin
                    // Carry out of the add is shifted into the top of the accumulator
                    if (p_lo_q[0]) begin
                        {p_hi_d, p_lo_d} = {sum_s, p_lo_q[WIDTH-1:1]};
                    end else begin
                        {p_hi_d, p_lo_d} = {1'b0, p_hi_q, p_lo_q[WIDTH-1:1]};
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
                case (op_q)
                    OP_MUL: begin
                        res_lo_d = prod_s[WIDTH-1:0];
                        res_hi_d = prod_s[2*WIDTH-1:WIDTH];
                        flags_d  = {prod_s[WIDTH-1], prod_s[WIDTH-1:0] == ZERO_W};
                    end
                    OP_UMULL, OP_SMULL: begin
                        res_lo_d = prod_s[WIDTH-1:0];
                        res_hi_d = prod_s[2*WIDTH-1:WIDTH];
                        flags_d  = {prod_s[2*WIDTH-1], prod_s == {(2*WIDTH){1'b0}}};
                    end
`ifdef MULDIV_DIV_EN
                    OP_DIV: begin
                        if (b_q == ZERO_W) begin
                            res_lo_d = {WIDTH{1'b1}};
                            res_hi_d = p_lo_q;
                            flags_d  = 2'b00;
                        end else begin
                            res_lo_d = p_lo_q;
                            res_hi_d = rem_q[WIDTH-1:0];
                            flags_d  = {1'b0, p_lo_q == ZERO_W};
                        end
                    end
`endif
                    default: begin
                        res_lo_d = ZERO_W;
                        res_hi_d = ZERO_W;
                        flags_d  = 2'b01;
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= 4'b0000;
            sign_q   <= 1'b0;
            b_q      <= ZERO_W;
            p_hi_q   <= ZERO_W;
            p_lo_q   <= ZERO_W;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_lo_q <= ZERO_W;
            res_hi_q <= ZERO_W;
            flags_q  <= 2'b00;
`ifdef MULDIV_DIV_EN
            rem_q    <= {(WIDTH+1){1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            b_q      <= b_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
`ifdef MULDIV_DIV_EN
            rem_q    <= rem_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ResultLo = res_lo_q;
    assign ResultHi = res_hi_q;
    assign MulFlags = flags_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; DIV expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] ResultLo;
    logic [31:0] ResultHi;
    logic [1:0]  MulFlags;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .busy       (busy),
        .done       (done),
        .ResultLo   (ResultLo),
        .ResultHi   (ResultHi),
        .MulFlags   (MulFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; that cycle is cycle 0 of the operation.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic [1:0] exp_fl, input int exp_lat, input bit poke);
        int lat;
        int busy_bad;
        start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        start = 1'b0; ALUControl = 4'b0110; SrcA = ~a; SrcB = ~b;
        lat = 1;
        busy_bad = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_bad++;
            start = poke && (lat == 10);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check_val({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, " busy"}, 64'(busy_bad), 64'd0);
        check_val({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check_val({tag, " lo"}, 64'(ResultLo), 64'(exp_lo));
        check_val({tag, " hi"}, 64'(ResultHi), 64'(exp_hi));
        check_val({tag, " flags"}, 64'(MulFlags), 64'(exp_fl));
    endtask

    initial begin
        int done_hits;
        reset = 1'b1; start = 1'b0; ALUControl = 4'b0000; SrcA = 32'd0; SrcB = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst busy", 64'(busy), 64'd0);
        check_val("rst done", 64'(done), 64'd0);
        check_val("rst lo", 64'(ResultLo), 64'd0);
        check_val("rst hi", 64'(ResultHi), 64'd0);
        check_val("rst flags", 64'(MulFlags), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back chain: each op starts in the done cycle of the previous one
        run_op("umull_max", 4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 2'b10, 34, 1'b0);
        run_op("smull_m2x3", 4'b1000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 2'b10, 34, 1'b0);
        run_op("smull_min", 4'b1000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 2'b00, 34, 1'b0);
        run_op("smull_5xm1", 4'b1000, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF, 2'b10, 34, 1'b0);
        run_op("smull_0xm7", 4'b1000, 32'h00000000, 32'hFFFFFFF9, 32'h00000000, 32'h00000000, 2'b01, 34, 1'b0);
        run_op("mul_hi", 4'b0100, 32'h00010000, 32'h00010001, 32'h00010000, 32'h00000001, 2'b00, 34, 1'b0);
        run_op("mul_neg", 4'b0100, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 2'b10, 34, 1'b0);
        run_op("mul_zero", 4'b0100, 32'h00000000, 32'h00001234, 32'h00000000, 32'h00000000, 2'b01, 34, 1'b1);
        @(posedge clk); #1;
        check_val("mul_zero done_once", 64'(done), 64'd0);

`ifdef MULDIV_DIV_EN
        run_op("div_100_7", 4'b0111, 32'd100, 32'd7, 32'd14, 32'd2, 2'b00, 34, 1'b0);
        run_op("div_5_0", 4'b0111, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 2'b00, 2, 1'b0);
        run_op("div_max_1", 4'b0111, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 2'b00, 34, 1'b0);
        run_op("div_3_10", 4'b0111, 32'd3, 32'd10, 32'd0, 32'd3, 2'b01, 34, 1'b0);
`else
        run_op("div_100_7", 4'b0111, 32'd100, 32'd7, 32'd0, 32'd0, 2'b01, 2, 1'b0);
        run_op("div_5_0", 4'b0111, 32'd5, 32'd0, 32'd0, 32'd0, 2'b01, 2, 1'b0);
`endif
        run_op("bad_op", 4'b1111, 32'd9, 32'd9, 32'd0, 32'd0, 2'b01, 2, 1'b0);
        run_op("umull_prev", 4'b0110, 32'h00000010, 32'h00000010, 32'h00000100, 32'h00000000, 2'b00, 34, 1'b0);

        // Abort a UMULL with reset in cycle 15
        start = 1'b1; ALUControl = 4'b0110; SrcA = 32'hFFFFFFFF; SrcB = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("abort busy", 64'(busy), 64'd0);
        check_val("abort done", 64'(done), 64'd0);
        check_val("abort lo", 64'(ResultLo), 64'd0);
        check_val("abort hi", 64'(ResultHi), 64'd0);
        check_val("abort flags", 64'(MulFlags), 64'd0);
        reset = 1'b0;
        done_hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_hits++;
        end
        check_val("abort no_done", 64'(done_hits), 64'd0);
        run_op("umull_3x4", 4'b0110, 32'd3, 32'd4, 32'd12, 32'd0, 2'b00, 34, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
